// File: rtl/piso_shift_tx_pkg.sv
// ---------------------------------------------------------------------------
// piso_shift_tx_pkg
// Shared definitions for the serial link blocks (transmitter now, receiver
// later): FSM state encoding and a constant-safe ceiling-log2 helper used to
// size bit counters.
// ---------------------------------------------------------------------------
package piso_shift_tx_pkg;

  // Two-state transmitter FSM.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Ceiling log2; usable in parameter/localparam context.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/piso_shift_tx_bit_counter.sv
// ---------------------------------------------------------------------------
// piso_shift_tx_bit_counter
// Modulo-MODULUS up-counter tracking the bit position within a serial word.
// Shared with the future receiver.
// Ports:
//   i_clk    in   clock, rising edge
//   i_rst_n  in   asynchronous active-low clear
//   i_start  in   synchronous load of 0 (has priority over i_en)
//   i_en     in   advance by one, wrapping MODULUS-1 -> 0
//   o_count  out  current count
//   o_tc     out  terminal count (count == MODULUS-1)
// ---------------------------------------------------------------------------
module piso_shift_tx_bit_counter #(
  parameter int MODULUS = 8,
  parameter int CNT_W   = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count,
  output logic             o_tc
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(MODULUS - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_start) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= (r_count == LAST) ? '0 : r_count + 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_tc    = (r_count == LAST);

endmodule

// File: rtl/piso_shift_tx.sv
// ---------------------------------------------------------------------------
// piso_shift_tx
// Parallel-in/serial-out transmitter. A word is accepted on a rising C edge
// where LOAD & READY, then sent one bit per clock on SO with SO_VALID framing
// and DONE flagging the last bit. Back-to-back words stream with no gap.
// Ports:
//   C         in   clock, rising edge
//   CLR       in   asynchronous active-low reset
//   D         in   parallel word (sampled only on the accepting edge)
//   LOAD      in   word valid
//   READY     out  a word can be accepted this cycle
//   SO        out  serial data (registered), IDLE_VAL when idle
//   SO_VALID  out  SO carries a data bit (registered)
//   DONE      out  last bit of a word is on SO (registered)
// ---------------------------------------------------------------------------
module piso_shift_tx
  import piso_shift_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_VAL   = 1'b1
) (
  input  logic                  C,
  input  logic                  CLR,
  input  logic [DATA_WIDTH-1:0] D,
  input  logic                  LOAD,
  output logic                  READY,
  output logic                  SO,
  output logic                  SO_VALID,
  output logic                  DONE
);

  localparam int               CNT_W  = clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] PENULT = CNT_W'(DATA_WIDTH - 2);

  state_t                r_state;
  state_t                w_state_next;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] w_shift_next;
  logic                  r_so;
  logic                  w_so_next;
  logic                  r_so_valid;
  logic                  w_so_valid_next;
  logic                  r_done;
  logic                  w_done_next;
  logic [CNT_W-1:0]      w_count;
  logic                  w_tc;
  logic                  w_ready;
  logic                  w_accept;
  logic                  w_cnt_en;

  // Bit that goes out first from a word, in the configured order.
  function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w);
    return MSB_FIRST ? w[DATA_WIDTH-1] : w[0];
  endfunction

  // Word with the first-sent bit consumed, so the next bit sits in first place.
  function automatic logic [DATA_WIDTH-1:0] shift_once(input logic [DATA_WIDTH-1:0] w);
    return MSB_FIRST ? {w[DATA_WIDTH-2:0], 1'b0} : {1'b0, w[DATA_WIDTH-1:1]};
  endfunction

  // Ready while idle and also during the last bit, which gives gap-free streaming.
  assign w_ready  = (r_state == ST_IDLE) | ((r_state == ST_SHIFT) & w_tc);
  assign w_accept = LOAD & w_ready;
  // The counter wraps to 0 on leaving the last bit, so it is already 0 in IDLE.
  assign w_cnt_en = (r_state == ST_SHIFT);

  piso_shift_tx_bit_counter #(
    .MODULUS (DATA_WIDTH),
    .CNT_W   (CNT_W)
  ) u_bit_counter (
    .i_clk   (C),
    .i_rst_n (CLR),
    .i_start (w_accept),
    .i_en    (w_cnt_en),
    .o_count (w_count),
    .o_tc    (w_tc)
  );

  // State register plus the registered datapath/outputs.
  always_ff @(posedge C or negedge CLR) begin
    if (!CLR) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_so       <= IDLE_VAL;
      r_so_valid <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_shift    <= w_shift_next;
      r_so       <= w_so_next;
      r_so_valid <= w_so_valid_next;
      r_done     <= w_done_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (LOAD) w_state_next = ST_SHIFT;
      ST_SHIFT: if (w_tc && !LOAD) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Output/datapath next values. The shift register always holds the bits
  // still to be sent, with the next one in first-bit position.
  always_comb begin
    w_shift_next    = r_shift;
    w_so_next       = IDLE_VAL;
    w_so_valid_next = 1'b0;
    w_done_next     = 1'b0;
    if (w_accept) begin
      w_shift_next    = shift_once(D);
      w_so_next       = first_bit(D);
      w_so_valid_next = 1'b1;
    end else if ((r_state == ST_SHIFT) && !w_tc) begin
      w_shift_next    = shift_once(r_shift);
      w_so_next       = first_bit(r_shift);
      w_so_valid_next = 1'b1;
      // Next bit is the last one when moving from W-2 to W-1.
      w_done_next     = (w_count == PENULT);
    end
  end

  assign READY    = w_ready;
  assign SO       = r_so;
  assign SO_VALID = r_so_valid;
  assign DONE     = r_done;

endmodule

// File: tb/tb_piso_shift_tx.sv
// ---------------------------------------------------------------------------
// tb_piso_shift_tx
// Directed bench for piso_shift_tx (8-bit). Two instances: MSB-first and
// LSB-first. Expected bit/done pairs are queued when a word is presented and
// popped whenever a bit is expected on SO.
// ---------------------------------------------------------------------------
module tb_piso_shift_tx;

  typedef struct packed {
    logic so;
    logic done;
  } exp_t;

  logic       clk = 1'b0;
  logic       clr_n;
  logic       load_m;
  logic [7:0] d_m;
  logic       load_l;
  logic [7:0] d_l;
  logic       ready_m, so_m, so_valid_m, done_m;
  logic       ready_l, so_l, so_valid_l, done_l;

  exp_t q_m[$];
  exp_t q_l[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  piso_shift_tx #(.DATA_WIDTH(8), .MSB_FIRST(1'b1), .IDLE_VAL(1'b1)) dut_msb (
    .C        (clk),
    .CLR      (clr_n),
    .D        (d_m),
    .LOAD     (load_m),
    .READY    (ready_m),
    .SO       (so_m),
    .SO_VALID (so_valid_m),
    .DONE     (done_m)
  );

  piso_shift_tx #(.DATA_WIDTH(8), .MSB_FIRST(1'b0), .IDLE_VAL(1'b1)) dut_lsb (
    .C        (clk),
    .CLR      (clr_n),
    .D        (d_l),
    .LOAD     (load_l),
    .READY    (ready_l),
    .SO       (so_l),
    .SO_VALID (so_valid_l),
    .DONE     (done_l)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] want);
    n_tests++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // Queue the 8 expected (bit, done) pairs of a word in send order.
  task automatic push_word(input logic [7:0] w, input bit lsb_inst);
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      e.so   = lsb_inst ? w[i] : w[7-i];
      e.done = (i == 7);
      if (lsb_inst) q_l.push_back(e);
      else          q_m.push_back(e);
    end
    $display("[TB] word 0x%02h queued on %s-first instance", w, lsb_inst ? "LSB" : "MSB");
  endtask

  task automatic check_inst(input bit lsb_inst, input logic ev, input logic so,
                            input logic vld, input logic dn);
    exp_t  e;
    int    sz;
    string tag;
    tag = lsb_inst ? "lsb" : "msb";
    sz  = lsb_inst ? q_l.size() : q_m.size();
    chk({tag, "_so_valid"}, {7'd0, vld}, {7'd0, ev});
    if (ev) begin
      n_tests++;
      assert (sz != 0) else begin
        n_fail++;
        $error("FAIL %s_scoreboard: observed=empty expected=entry", tag);
      end
      if (sz != 0) begin
        if (lsb_inst) e = q_l.pop_front();
        else          e = q_m.pop_front();
        chk({tag, "_so"},   {7'd0, so}, {7'd0, e.so});
        chk({tag, "_done"}, {7'd0, dn}, {7'd0, e.done});
      end
    end else begin
      chk({tag, "_idle_so"},   {7'd0, so}, 8'd1);
      chk({tag, "_idle_done"}, {7'd0, dn}, 8'd0);
    end
  endtask

  // One clock; sample both instances 1 time unit after the rising edge.
  task automatic step(input logic ev_m, input logic ev_l);
    @(posedge clk);
    #1;
    check_inst(1'b0, ev_m, so_m, so_valid_m, done_m);
    check_inst(1'b1, ev_l, so_l, so_valid_l, done_l);
  endtask

  initial begin
    // Test 1: reset with LOAD asserted and D all ones
    clr_n  = 1'b1;
    load_m = 1'b1;
    d_m    = 8'hFF;
    load_l = 1'b1;
    d_l    = 8'hFF;
    #2;
    clr_n  = 1'b0;
    repeat (3) step(1'b0, 1'b0);
    clr_n  = 1'b1;
    load_m = 1'b0;
    load_l = 1'b0;
    #1;
    chk("ready_after_reset_msb", {7'd0, ready_m}, 8'd1);
    chk("ready_after_reset_lsb", {7'd0, ready_l}, 8'd1);

    // Test 2: single word A5, MSB first
    d_m    = 8'hA5;
    load_m = 1'b1;
    push_word(8'hA5, 1'b0);
    step(1'b1, 1'b0);
    load_m = 1'b0;
    d_m    = 8'h00;
    chk("ready_busy_bit0", {7'd0, ready_m}, 8'd0);
    repeat (7) step(1'b1, 1'b0);
    chk("ready_last_bit", {7'd0, ready_m}, 8'd1);
    step(1'b0, 1'b0);
    chk("a5_drained", 8'(q_m.size()), 8'd0);

    // Test 3: word 01, LSB first
    d_l    = 8'h01;
    load_l = 1'b1;
    push_word(8'h01, 1'b1);
    step(1'b0, 1'b1);
    load_l = 1'b0;
    repeat (7) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    chk("lsb_01_drained", 8'(q_l.size()), 8'd0);

    // Test 4: back-to-back 0F then F0 with LOAD held
    d_m    = 8'h0F;
    load_m = 1'b1;
    push_word(8'h0F, 1'b0);
    step(1'b1, 1'b0);
    d_m    = 8'hF0;
    push_word(8'hF0, 1'b0);
    repeat (7) step(1'b1, 1'b0);
    chk("b2b_ready_at_bit8", {7'd0, ready_m}, 8'd1);
    step(1'b1, 1'b0);
    load_m = 1'b0;
    repeat (7) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("b2b_drained", 8'(q_m.size()), 8'd0);

    // Test 5: LOAD while busy is ignored
    d_m    = 8'h3C;
    load_m = 1'b1;
    push_word(8'h3C, 1'b0);
    step(1'b1, 1'b0);
    load_m = 1'b0;
    repeat (2) step(1'b1, 1'b0);
    load_m = 1'b1;
    d_m    = 8'hFF;
    repeat (3) step(1'b1, 1'b0);
    load_m = 1'b0;
    repeat (2) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("busy_ignore_drained", 8'(q_m.size()), 8'd0);

    // Test 6: asynchronous reset mid-word, then a fresh word
    d_m    = 8'hC3;
    load_m = 1'b1;
    push_word(8'hC3, 1'b0);
    step(1'b1, 1'b0);
    load_m = 1'b0;
    repeat (4) step(1'b1, 1'b0);
    #2;
    clr_n = 1'b0;
    #1;
    chk("async_clr_so",       {7'd0, so_m},       8'd1);
    chk("async_clr_so_valid", {7'd0, so_valid_m}, 8'd0);
    chk("async_clr_done",     {7'd0, done_m},     8'd0);
    chk("async_clr_ready",    {7'd0, ready_m},    8'd1);
    q_m.delete();
    step(1'b0, 1'b0);
    clr_n  = 1'b1;
    d_m    = 8'h81;
    load_m = 1'b1;
    push_word(8'h81, 1'b0);
    step(1'b1, 1'b0);
    load_m = 1'b0;
    repeat (7) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("after_reset_drained", 8'(q_m.size()), 8'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
